// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller with 8-word lines.
// Define DCACHE_STATS_EN to add hit/miss counter outputs.
module dcache_ctrl #(
    parameter int INDEX_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic         cpu_read_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o,
`endif
    input  logic         mem_ack_i
);

    localparam int TAG_W = 32 - 5 - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        FILL_DONE = 2'd3
    } state_t;

    state_t state;

    logic [255:0]       data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         off;
    logic               req;
    logic               hit;
    logic [255:0]       rd_line;
    logic [1:0]         unused_addr_bits;

    assign idx              = cpu_addr_i[4+INDEX_W:5];
    assign tag              = cpu_addr_i[31:5+INDEX_W];
    assign off              = cpu_addr_i[4:2];
    assign unused_addr_bits = cpu_addr_i[1:0];
    assign req              = cpu_read_i | cpu_write_i;
    assign hit              = valid_q[idx] & (tag_mem[idx] == tag);
    assign rd_line          = data_mem[idx];
    assign stall_o          = req & ~((state == IDLE) & hit);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cpu_data_o = '0;
        if (hit)
            cpu_data_o = rd_line[{off, 5'b0} +: 32];
    end

    // NOTE: line data and tags are plain storage with no reset; valid_q gates every use of them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == REFILL && mem_ack_i) begin
                data_mem[idx] <= mem_data_i;
                tag_mem[idx]  <= tag;
            end else if (state == IDLE && req && hit && cpu_write_i) begin
                data_mem[idx][{off, 5'b0} +: 32] <= cpu_data_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit && cpu_write_i) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (req && !hit) begin
                        mem_req_o <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state      <= WRITEBACK;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= {tag_mem[idx], idx, 5'b0};
                            mem_data_o <= data_mem[idx];
                        end else begin
                            state      <= REFILL;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {cpu_addr_i[31:5], 5'b0};
                        end
                    end
                end
                WRITEBACK: begin
                    // Fetch follows immediately; the state change separates the two transactions.
                    if (mem_ack_i) begin
                        state      <= REFILL;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {cpu_addr_i[31:5], 5'b0};
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state        <= FILL_DONE;
                        mem_req_o    <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                FILL_DONE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The IDLE hit that completes a miss is not a genuine hit; refilled masks it.
    logic refilled;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            refilled   <= 1'b0;
        end else begin
            if (state == FILL_DONE)
                refilled <= 1'b1;
            else if (state == IDLE)
                refilled <= 1'b0;
            if (state == IDLE && req && hit && !refilled)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if (state == IDLE && req && !hit)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a line-memory model and a load monitor pop expected responses.
module tb_dcache_ctrl;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] data;
        int           lat;
    } mem_exp_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic         cpu_read_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit hold_chk = 1'b1;

    logic [31:0]  exp_rd [$];
    mem_exp_t     exp_mem [$];
    logic [255:0] line_store [logic [26:0]];

    dcache_ctrl dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_read_i (cpu_read_i),
        .cpu_write_i(cpu_write_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt),
`endif
        .mem_ack_i  (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int n = 0; n < 8; n++) l[32*n +: 32] = base + 32'(n);
        return l;
    endfunction

    // Line-memory model: checks each new transaction against the scoreboard, acks after its latency.
    initial begin
        mem_exp_t     e;
        logic         we_s;
        logic [31:0]  addr_s;
        logic [255:0] data_s;
        int           lat;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (mem_req_o && !rst_i) begin
                we_s   = mem_we_o;
                addr_s = mem_addr_o;
                data_s = mem_data_o;
                lat    = 1;
                if (exp_mem.size() == 0) begin
                    fail_now("mem_unexpected_req");
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_we", we_s, e.we);
                    check("mem_addr", addr_s, e.addr);
                    if (e.we) check("mem_wb_data", data_s, e.data);
                    lat = e.lat;
                end
                repeat (lat - 1) @(negedge clk_i);
                if (hold_chk) begin
                    check("mem_hold_ctl", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, we_s, addr_s});
                    if (we_s) check("mem_hold_data", mem_data_o, data_s);
                end
                if (we_s) line_store[addr_s[31:5]] = data_s;
                else mem_data_i = line_store.exists(addr_s[31:5]) ? line_store[addr_s[31:5]] : '0;
                mem_ack_i = 1'b1;
            end
        end
    end

    // Load monitor: every completed load is compared with the next expected word.
    always @(negedge clk_i) begin
        if (!rst_i && cpu_read_i && !cpu_write_i && !stall_o) begin
            if (exp_rd.size() == 0) fail_now("rd_unexpected");
            else check("rd_data", cpu_data_o, exp_rd.pop_front());
        end
    end

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i       = 1'b1;
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input int exp_stall, input string name);
        int n;
        @(posedge clk_i); #1;
        cpu_read_i  = rd;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = data;
        n = 0;
        @(negedge clk_i);
        while (stall_o && n < 300) begin
            n++;
            @(negedge clk_i);
        end
        check(name, 256'(n), 256'(exp_stall));
    endtask

    task automatic idle();
        @(posedge clk_i); #1;
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
    endtask

    initial begin
        logic [255:0] l100;
        logic [255:0] l40;
        int           n;
        rst_i = 1'b1; cpu_addr_i = '0; cpu_read_i = 1'b0; cpu_write_i = 1'b0; cpu_data_i = '0;
        line_store[27'h08] = mk_line(32'h1000_0000);
        l100 = line_store[27'h08];
        l100[63:32] = 32'hDEAD_BEEF;
        line_store[27'h08] = l100;
        line_store[27'h18] = mk_line(32'h3000_0000);
        line_store[27'h02] = mk_line(32'h4000_0000);
        line_store[27'h12] = mk_line(32'h2400_0000);

        do_reset();
        @(negedge clk_i);
        check("rst_outputs", {mem_req_o, mem_we_o, stall_o, mem_addr_o, cpu_data_o}, '0);
        check("rst_mem_data", mem_data_o, '0);
`ifdef DCACHE_STATS_EN
        check("rst_counters", {hit_cnt, miss_cnt}, '0);
`endif

        // Cold read miss: refill 0x100, 10-cycle memory -> 12 stall cycles.
        exp_mem.push_back('{we: 1'b0, addr: 32'h100, data: '0, lat: 10});
        exp_rd.push_back(32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0104, '0, 12, "cold_read_stall");

        // Write hit then read-back, both without stall or memory traffic.
        access(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 0, "write_hit_stall");
        exp_rd.push_back(32'h1234_5678);
        access(1'b1, 1'b0, 32'h0000_0104, '0, 0, "read_hit_stall");

        // Dirty conflict at index 8: write back 0x100, refill 0x300 -> 2+4+6 stall cycles.
        l100 = mk_line(32'h1000_0000);
        l100[63:32] = 32'h1234_5678;
        exp_mem.push_back('{we: 1'b1, addr: 32'h100, data: l100, lat: 4});
        exp_mem.push_back('{we: 1'b0, addr: 32'h300, data: '0, lat: 6});
        exp_rd.push_back(32'h3000_0001);
        access(1'b1, 1'b0, 32'h0000_0304, '0, 12, "conflict_stall");
        idle();
`ifdef DCACHE_STATS_EN
        @(negedge clk_i);
        check("hit_cnt", hit_cnt, 32'd2);
        check("miss_cnt", miss_cnt, 32'd2);
`endif

        // Reset three cycles into REFILL; the late ack must be ignored.
        exp_mem.push_back('{we: 1'b0, addr: 32'h100, data: '0, lat: 10});
        @(posedge clk_i); #1;
        cpu_read_i = 1'b1;
        cpu_addr_i = 32'h0000_0104;
        repeat (4) @(negedge clk_i);
        hold_chk = 1'b0;
        @(posedge clk_i); #1;
        rst_i      = 1'b1;
        cpu_read_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_refill", {mem_req_o, stall_o}, 2'b00);
        n = 0;
        @(posedge clk_i);
        while (!mem_ack_i && n < 50) begin
            n++;
            @(posedge clk_i);
        end
        if (n >= 50) fail_now("late_ack_timeout");
        @(negedge clk_i);
        check("late_ack_ignored", {mem_req_o, stall_o}, 2'b00);
        hold_chk = 1'b1;
        // Written-back word comes back from memory after the re-miss.
        exp_mem.push_back('{we: 1'b0, addr: 32'h100, data: '0, lat: 3});
        exp_rd.push_back(32'h1234_5678);
        access(1'b1, 1'b0, 32'h0000_0104, '0, 5, "remiss_stall");
        idle();

        // Clean write miss: refill only, merge store, later evicted as dirty.
        do_reset();
        exp_mem.push_back('{we: 1'b0, addr: 32'h40, data: '0, lat: 5});
        access(1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 7, "write_miss_stall");
        exp_rd.push_back(32'hA5A5_A5A5);
        access(1'b1, 1'b0, 32'h0000_0040, '0, 0, "write_miss_readback");
        l40 = mk_line(32'h4000_0000);
        l40[31:0] = 32'hA5A5_A5A5;
        exp_mem.push_back('{we: 1'b1, addr: 32'h40, data: l40, lat: 3});
        exp_mem.push_back('{we: 1'b0, addr: 32'h240, data: '0, lat: 2});
        exp_rd.push_back(32'h2400_0000);
        access(1'b1, 1'b0, 32'h0000_0240, '0, 7, "evict_stall");
        idle();

        repeat (3) @(negedge clk_i);
        check("exp_rd_drained", 256'(exp_rd.size()), '0);
        check("exp_mem_drained", 256'(exp_mem.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
